// File: rtl/game_setup_ctrl.sv
// Purpose: computes board geometry, mine/timer config and won/lost statistics for the selected level.
// Latency: setup_valid pulses in the (DATA_W+8)th cycle after the accept edge (20 at DATA_W=12).
// Backpressure: setup_ready is low while busy; requests made while busy are dropped, not queued.
// Optional feature: define GAME_SETUP_STATS_EN to build the won/lost counters (tied to 0 otherwise).
module game_setup_ctrl #(
    parameter int DATA_W    = 12,
    parameter int V_DISPLAY = 768,
    parameter int X_CENTER  = 512,
    parameter int Y_CENTER  = 384,
    parameter int MAX_FIELD = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        level_sel,
    input  logic [4:0]        custom_rows,
    input  logic [DATA_W-1:0] custom_mines,
    input  logic [DATA_W-1:0] custom_timer,
    input  logic              setup_req,
    output logic              setup_ready,
    output logic              setup_valid,
    output logic [4:0]        rows,
    output logic [DATA_W-1:0] mines,
    output logic [DATA_W-1:0] timer_seconds,
    output logic [DATA_W-1:0] field_size,
    output logic [DATA_W-1:0] board_size,
    output logic [DATA_W-1:0] board_xpos,
    output logic [DATA_W-1:0] board_ypos,
    input  logic              game_won,
    input  logic              game_lost,
    input  logic              stats_clr,
    output logic [DATA_W-1:0] games_won,
    output logic [DATA_W-1:0] games_lost
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_MUL, S_POS, S_DONE} state_t;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]  MUL_LAST = CNT_W'(4);
    localparam logic [DATA_W-1:0] VDISP    = DATA_W'(V_DISPLAY);
    localparam logic [DATA_W-1:0] XC       = DATA_W'(X_CENTER);
    localparam logic [DATA_W-1:0] YC       = DATA_W'(Y_CENTER);
    localparam logic [DATA_W-1:0] MAXF     = DATA_W'(MAX_FIELD);

    state_t state, state_nxt;

    logic [1:0]        lvl_q;
    logic [4:0]        crows_q;
    logic [DATA_W-1:0] cmines_q, ctimer_q;
    logic [4:0]        rows_w;
    logic [DATA_W-1:0] mines_w, timer_w;
    logic [DATA_W-1:0] rem_q, quo_q, fld_q;
    logic [DATA_W-1:0] brd_q, cel_q, mb_q, mc_q;
    logic [4:0]        mr_q;
    logic [CNT_W-1:0]  cnt_q;

    // Restoring-divide step: shift the next dividend bit into the partial remainder and trial-subtract.
    logic [DATA_W-1:0] rows_ext, rem_sh, rem_nxt, quo_nxt, fld_nxt;
    logic              div_ge;
    assign rows_ext = {{(DATA_W-5){1'b0}}, rows_w};
    assign rem_sh   = {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
    assign div_ge   = (rem_sh >= rows_ext);
    assign rem_nxt  = div_ge ? (rem_sh - rows_ext) : rem_sh;
    assign quo_nxt  = {quo_q[DATA_W-2:0], div_ge};
    assign fld_nxt  = (quo_nxt > MAXF) ? MAXF : quo_nxt;

    // Position and mine clamp, evaluated from the finished products during POS.
    logic [DATA_W-1:0] half_b, xpos_c, ypos_c, mines_c;
    assign half_b  = brd_q >> 1;
    assign xpos_c  = (half_b > XC) ? '0 : (XC - half_b);
    assign ypos_c  = (half_b > YC) ? '0 : (YC - half_b);
    assign mines_c = (mines_w >= cel_q) ? (cel_q - DATA_W'(1)) : mines_w;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt   = state;
        setup_ready = 1'b0;
        setup_valid = 1'b0;
        case (state)
            S_IDLE: begin
                setup_ready = 1'b1;
                if (setup_req) state_nxt = S_LOAD;
            end
            S_LOAD: state_nxt = S_DIV;
            S_DIV:  if (cnt_q == DIV_LAST) state_nxt = S_MUL;
            S_MUL:  if (cnt_q == MUL_LAST) state_nxt = S_POS;
            S_POS:  state_nxt = S_DONE;
            S_DONE: begin
                setup_valid = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: latch request, select level, divide, multiply, then publish all outputs at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q <= '0; crows_q <= '0; cmines_q <= '0; ctimer_q <= '0;
            rows_w <= '0; mines_w <= '0; timer_w <= '0;
            rem_q <= '0; quo_q <= '0; fld_q <= '0;
            brd_q <= '0; cel_q <= '0; mb_q <= '0; mc_q <= '0; mr_q <= '0;
            cnt_q <= '0;
            rows <= '0; mines <= '0; timer_seconds <= '0; field_size <= '0;
            board_size <= '0; board_xpos <= '0; board_ypos <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (setup_req) begin
                        lvl_q    <= level_sel;
                        crows_q  <= custom_rows;
                        cmines_q <= custom_mines;
                        ctimer_q <= custom_timer;
                    end
                end
                S_LOAD: begin
                    case (lvl_q)
                        2'd0: begin rows_w <= 5'd8;  mines_w <= DATA_W'(19); timer_w <= DATA_W'(45); end
                        2'd1: begin rows_w <= 5'd10; mines_w <= DATA_W'(30); timer_w <= DATA_W'(50); end
                        2'd2: begin rows_w <= 5'd15; mines_w <= DATA_W'(40); timer_w <= DATA_W'(70); end
                        default: begin
                            rows_w  <= (crows_q < 5'd2) ? 5'd2 : crows_q;
                            mines_w <= (cmines_q == '0) ? DATA_W'(1) : cmines_q;
                            timer_w <= ctimer_q;
                        end
                    endcase
                    rem_q <= '0;
                    quo_q <= VDISP;
                    cnt_q <= '0;
                end
                S_DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    if (cnt_q == DIV_LAST) begin
                        fld_q <= fld_nxt;
                        mb_q  <= fld_nxt;
                        mc_q  <= rows_ext;
                        mr_q  <= rows_w;
                        brd_q <= '0;
                        cel_q <= '0;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_MUL: begin
                    if (mr_q[0]) begin
                        brd_q <= brd_q + mb_q;
                        cel_q <= cel_q + mc_q;
                    end
                    mb_q  <= mb_q << 1;
                    mc_q  <= mc_q << 1;
                    mr_q  <= mr_q >> 1;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_POS: begin
                    rows          <= rows_w;
                    mines         <= mines_c;
                    timer_seconds <= timer_w;
                    field_size    <= fld_q;
                    board_size    <= brd_q;
                    board_xpos    <= xpos_c;
                    board_ypos    <= ypos_c;
                end
                default: ;
            endcase
        end
    end

`ifdef GAME_SETUP_STATS_EN
    // Saturating won/lost counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            games_won  <= '0;
            games_lost <= '0;
        end else if (stats_clr) begin
            games_won  <= '0;
            games_lost <= '0;
        end else begin
            if (game_won && (games_won != '1))   games_won  <= games_won + DATA_W'(1);
            if (game_lost && (games_lost != '1)) games_lost <= games_lost + DATA_W'(1);
        end
    end
`else
    logic unused_stats;
    assign unused_stats = game_won ^ game_lost ^ stats_clr;
    assign games_won    = '0;
    assign games_lost   = '0;
`endif

endmodule

// File: tb/tb_game_setup_ctrl.sv
// Purpose: randomized self-checking bench for game_setup_ctrl against a behavioural model.
// Latency: expects setup_valid 20 cycles after the accept edge.
// Backpressure: exercises requests held through busy and a reset in mid-operation.
module tb_game_setup_ctrl;
    localparam int DW = 12;
`ifdef GAME_SETUP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    level_sel = '0;
    logic [4:0]    custom_rows = '0;
    logic [DW-1:0] custom_mines = '0, custom_timer = '0;
    logic          setup_req = 1'b0;
    logic          setup_ready, setup_valid;
    logic [4:0]    rows;
    logic [DW-1:0] mines, timer_seconds, field_size, board_size, board_xpos, board_ypos;
    logic          game_won = 1'b0, game_lost = 1'b0, stats_clr = 1'b0;
    logic [DW-1:0] games_won, games_lost;

    game_setup_ctrl dut (
        .clk(clk), .rst(rst), .level_sel(level_sel), .custom_rows(custom_rows),
        .custom_mines(custom_mines), .custom_timer(custom_timer), .setup_req(setup_req),
        .setup_ready(setup_ready), .setup_valid(setup_valid), .rows(rows), .mines(mines),
        .timer_seconds(timer_seconds), .field_size(field_size), .board_size(board_size),
        .board_xpos(board_xpos), .board_ypos(board_ypos), .game_won(game_won),
        .game_lost(game_lost), .stats_clr(stats_clr), .games_won(games_won),
        .games_lost(games_lost)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int rows; int mines; int timer; int field; int board; int x; int y;
    } cfg_t;

    cfg_t prev;
    int   exp_won = 0, exp_lost = 0;

    function automatic cfg_t model(input int lvl, input int cr, input int cm, input int ct);
        cfg_t c;
        int half, cells;
        case (lvl)
            0: begin c.rows = 8;  c.mines = 19; c.timer = 45; end
            1: begin c.rows = 10; c.mines = 30; c.timer = 50; end
            2: begin c.rows = 15; c.mines = 40; c.timer = 70; end
            default: begin
                c.rows  = (cr < 2) ? 2 : cr;
                c.mines = (cm == 0) ? 1 : cm;
                c.timer = ct;
            end
        endcase
        c.field = 768 / c.rows;
        if (c.field > 64) c.field = 64;
        c.board = c.field * c.rows;
        half    = c.board / 2;
        c.x     = (half > 512) ? 0 : 512 - half;
        c.y     = (half > 384) ? 0 : 384 - half;
        cells   = c.rows * c.rows;
        if (c.mines >= cells) c.mines = cells - 1;
        return c;
    endfunction

    task automatic check_cfg(input string pfx, input cfg_t e);
        chk({pfx, ".rows"},  int'(rows),          e.rows);
        chk({pfx, ".mines"}, int'(mines),         e.mines);
        chk({pfx, ".timer"}, int'(timer_seconds), e.timer);
        chk({pfx, ".field"}, int'(field_size),    e.field);
        chk({pfx, ".board"}, int'(board_size),    e.board);
        chk({pfx, ".xpos"},  int'(board_xpos),    e.x);
        chk({pfx, ".ypos"},  int'(board_ypos),    e.y);
    endtask

    task automatic run_setup(input int lvl, input int cr, input int cm, input int ct, input bit hold);
        cfg_t e;
        int k;
        e = model(lvl, cr, cm, ct);
        level_sel    = 2'(lvl);
        custom_rows  = 5'(cr);
        custom_mines = DW'(cm);
        custom_timer = DW'(ct);
        setup_req    = 1'b1;
        @(posedge clk); #1;
        if (!hold) setup_req = 1'b0;
        // scramble inputs after the accept edge; the latched copy must be used
        level_sel    = 2'($urandom);
        custom_rows  = 5'($urandom);
        custom_mines = DW'($urandom);
        custom_timer = DW'($urandom);
        k = 1;
        while (k <= 40) begin
            if (setup_valid) break;
            chk("ready_busy", int'(setup_ready), 0);
            if (k == 10) check_cfg("hold", prev);
            @(posedge clk); #1;
            k++;
        end
        chk("latency", k, 20);
        chk("ready_done", int'(setup_ready), 0);
        check_cfg("cfg", e);
        setup_req = 1'b0;
        @(posedge clk); #1;
        chk("valid_once", int'(setup_valid), 0);
        chk("ready_idle", int'(setup_ready), 1);
        prev = e;
    endtask

    task automatic stats_cycle(input bit w, input bit l, input bit c);
        game_won = w; game_lost = l; stats_clr = c;
        @(posedge clk); #1;
        if (STATS) begin
            if (c) begin
                exp_won = 0; exp_lost = 0;
            end else begin
                if (w && exp_won < 4095)  exp_won++;
                if (l && exp_lost < 4095) exp_lost++;
            end
        end
        game_won = 1'b0; game_lost = 1'b0; stats_clr = 1'b0;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, ".won"},  int'(games_won),  exp_won);
        chk({tag, ".lost"}, int'(games_lost), exp_lost);
    endtask

    initial begin
        cfg_t z;
        z = '{0, 0, 0, 0, 0, 0, 0};
        prev = z;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready", int'(setup_ready), 1);
        chk("rst.valid", int'(setup_valid), 0);
        check_cfg("rst", z);
        chk_stats("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst.ready", int'(setup_ready), 1);

        // directed levels and custom boundaries
        run_setup(0, 0, 0, 0, 1'b0);
        run_setup(2, 0, 0, 0, 1'b0);
        run_setup(1, 0, 0, 0, 1'b0);
        run_setup(3, 4, 20, 99, 1'b0);
        run_setup(3, 1, 0, 7, 1'b0);
        run_setup(3, 31, 4095, 4095, 1'b0);
        run_setup(3, 0, 3, 1, 1'b1);

        // randomized requests, some held across the busy window
        for (int i = 0; i < 30; i++) begin
            int cm;
            cm = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 4095));
            run_setup(int'($urandom_range(0, 3)), int'($urandom_range(0, 31)), cm,
                      int'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
        end

        // reset in the middle of a configuration
        level_sel = 2'd2;
        setup_req = 1'b1;
        @(posedge clk); #1;
        setup_req = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        check_cfg("midrst", z);
        chk("midrst.valid", int'(setup_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        prev = z;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (setup_valid || !setup_ready) begin
                chk("midrst.novalid", int'(setup_valid), 0);
                chk("midrst.ready", int'(setup_ready), 1);
            end
        end
        chk("midrst.ready_end", int'(setup_ready), 1);
        check_cfg("midrst_end", z);
        run_setup(0, 0, 0, 0, 1'b0);

        // statistics: simultaneous events, randomized traffic, saturation, clear priority
        exp_won = 0; exp_lost = 0;
        repeat (3) stats_cycle(1'b1, 1'b1, 1'b0);
        chk_stats("both3");
        for (int i = 0; i < 200; i++) begin
            stats_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 15) == 0));
            chk_stats("rand");
        end
        stats_cycle(1'b0, 1'b0, 1'b1);
        repeat (4100) stats_cycle(1'b1, 1'b0, 1'b0);
        chk_stats("sat");
        stats_cycle(1'b1, 1'b1, 1'b0);
        chk_stats("sat_hold");
        stats_cycle(1'b1, 1'b0, 1'b1);
        chk_stats("clr_prio");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
